wb_mem_slave: RTL and testbench
===============================

Name: wb_mem_slave

Overview:
- Wishbone B4 classic-cycle slave with internal word-addressed RAM and a configurable wait-state counter.
- It is the responder end of the execute/memory stage's data bus.
- In simulation top-levels it stands in for data memory behind the exm Wishbone master; on FPGA it serves as a small scratchpad.
- No stall signal: the master holds stb until ack.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >=4
WAIT_CYCLES, 1, extra cycles between request sample and ack (0..15)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
wb_adr_i  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid while wb_ack_o=1
wb_we_i  in  1  1=write, 0=read
wb_sel_i  in  4  byte lane enables, bit n -> bits [8n+7:8n]
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  bus cycle
wb_ack_o  out  1  single-cycle acknowledge

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, state=IDLE, wait counter=0. RAM contents are not reset.
- Reset is asynchronous. If it is asserted mid-transaction, the slave goes to IDLE immediately, no ack is issued, and an uncommitted write is dropped.
- Word index = wb_adr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, WAIT, ACK. wb_ack_o is registered and equals (state==ACK).
- IDLE:
  - On cyc&stb, latch adr/we/sel/dat.
  - If WAIT_CYCLES=0, go to ACK.
  - Otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - If cyc=0, abort to IDLE: no ack, no write.
  - Else if cnt=0, go to ACK.
  - Else decrement cnt.
- Commit: on the edge entering ACK:
  - Writes update only the lanes with sel=1.
  - Reads load the full word into wb_dat_o, independent of sel.
  - sel=0000 write: no RAM change, still acked.
- ACK:
  - Lasts exactly one cycle, then always goes to IDLE.
  - stb/cyc sampled during the ACK cycle is ignored, so a held strobe is never acked twice.
  - The next request is sampled in IDLE.
  - cyc dropping during ACK does not cancel the ack; the commit has already happened.
- Latency: ack is high WAIT_CYCLES+1 cycles after the edge that sampled cyc&stb in IDLE. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- wb_dat_o holds its last read value outside ack; writes do not change it.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Optional Feature:
- Macro: WB_MEM_SLAVE_ERR_EN.
- Defined:
  - Adds port wb_err_o (out, 1, reset 0).
  - Requests with wb_adr_i >= DEPTH*4 or wb_adr_i[1:0]!=0 follow the same FSM timing.
  - In the final cycle they assert wb_err_o instead of wb_ack_o.
  - No RAM write, and wb_dat_o is unchanged.
  - Exactly one of ack/err is high per completed request.
- Undefined:
  - No wb_err_o port.
  - Out-of-range addresses wrap and misaligned low bits are ignored, as above.

Decomposition:
- Shared package ecap5_dproc_pkg gains:
  - typedef wb_mem_state_t {IDLE, WAIT, ACK}
  - constant WB_SEL_W = 4
- Sub-module wb_mem_ram holds the RAM array:
  - single port, one write port with byte enables, registered read.
  - Parameter DEPTH.
  - It contains no control logic, so it can map to a BRAM.

Test Plan:
- WAIT_CYCLES=1: write adr 0x10, dat 0xDEADBEEF, sel 1111; then read adr 0x10 -> ack 2 cycles after each request sample; read data 0xDEADBEEF.
- Byte lanes: write 0x11223344 sel 1111, then 0xAABBCCDD sel 0101 to adr 0x20; read -> 0x11BB33DD. sel=0000 write -> acked, word unchanged.
- Held strobe: master keeps stb=1 through ack and one extra cycle -> exactly one ack per request; second request acked WAIT_CYCLES+2 cycles after the first.
- Abort: WAIT_CYCLES=3, drop cyc after 1 cycle in WAIT during a write of 0xCAFEF00D to 0x40 -> no ack; read 0x40 returns prior value.
- Reset mid-op: assert rst_ni=0 in WAIT -> wb_ack_o=0 immediately, next request served normally; RAM word at 0x10 still 0xDEADBEEF.
- Wrap / err:
  - DEPTH=1024, undefined macro: write to 0x1010 -> read 0x10 returns it.
  - Defined macro: same request -> wb_err_o=1, wb_ack_o=0, 0x10 unchanged.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared types and constants for the data-side processor blocks
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_mem_state_t;

  localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_mem_ram.sv
// rtl/wb_mem_ram.sv - single-port word RAM with byte-lane write enables and registered read
import ecap5_dproc_pkg::*;

module wb_mem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [WB_SEL_W-1:0]      sel_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (sel_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Only the output register is reset; the array itself stays uninitialised
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - Wishbone B4 classic slave over word RAM with programmable wait states
// Optional macro WB_MEM_SLAVE_ERR_EN adds wb_err_o for out-of-range or misaligned requests.
import ecap5_dproc_pkg::*;

module wb_mem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o
`ifdef WB_MEM_SLAVE_ERR_EN
  ,
  output logic                wb_err_o
`endif
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  wb_mem_state_t       state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       adr_q;
  logic [31:0]         dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic                we_q, err_q;

  logic                capture, commit, req_err;
  logic [AW-1:0]       cur_adr;
  logic [31:0]         cur_dat;
  logic [WB_SEL_W-1:0] cur_sel;
  logic                cur_we, cur_err;
  logic                ram_we, ram_re;
  logic                unused_adr;

`ifdef WB_MEM_SLAVE_ERR_EN
  localparam logic [32:0] ADR_LIMIT = 33'(DEPTH) << 2;
  assign req_err = ({1'b0, wb_adr_i} >= ADR_LIMIT) || (wb_adr_i[1:0] != 2'b00);
`else
  assign req_err = 1'b0;
`endif

  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  // With zero wait states the commit happens on the sampling edge, so the bus feeds the RAM directly
  always_comb begin
    cur_adr = wb_adr_i[AW+1:2];
    cur_dat = wb_dat_i;
    cur_sel = wb_sel_i;
    cur_we  = wb_we_i;
    cur_err = req_err;
    if (state_q != IDLE) begin
      cur_adr = adr_q;
      cur_dat = dat_q;
      cur_sel = sel_q;
      cur_we  = we_q;
      cur_err = err_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        adr_q <= wb_adr_i[AW+1:2];
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        we_q  <= wb_we_i;
        err_q <= req_err;
      end
    end
  end

  // Gating with rst_ni keeps a zero-wait write from landing while reset is held
  assign ram_we = commit && cur_we && !cur_err && rst_ni;
  assign ram_re = commit && !cur_we && !cur_err;

  wb_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .sel_i  (cur_sel),
    .addr_i (cur_adr),
    .wdata_i(cur_dat),
    .rdata_o(wb_dat_o)
  );

`ifdef WB_MEM_SLAVE_ERR_EN
  assign wb_ack_o = (state_q == ACK) && !err_q;
  assign wb_err_o = (state_q == ACK) && err_q;
`else
  assign wb_ack_o = (state_q == ACK);
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - directed bench for wb_mem_slave at one and three wait states
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        we [2];
  logic [3:0]  sel [2];
  logic        stb [2];
  logic        cyc [2];
  logic        ack [2];
  logic        err [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_mem_slave #(.DEPTH(1024), .WAIT_CYCLES(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0])
`ifdef WB_MEM_SLAVE_ERR_EN
    , .wb_err_o(err[0])
`endif
  );

  wb_mem_slave #(.DEPTH(1024), .WAIT_CYCLES(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1])
`ifdef WB_MEM_SLAVE_ERR_EN
    , .wb_err_o(err[1])
`endif
  );

`ifndef WB_MEM_SLAVE_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one classic request from a negedge; lat counts negedges until ack/err is seen
  task automatic req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic [31:0] rd,
                     output logic ackv, output logic errv);
    adr[i] = a; wdat[i] = d; we[i] = w; sel[i] = s; cyc[i] = 1'b1; stb[i] = 1'b1;
    lat = -1; rd = '0; ackv = 1'b0; errv = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[i] || err[i]) begin
        lat = k; rd = rdat[i]; ackv = ack[i]; errv = err[i];
        break;
      end
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
    @(negedge clk);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        ackv, errv;
  logic        exp_held [5];

  initial begin
    exp_held = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; wdat[i] = '0; we[i] = 1'b0; sel[i] = '0; stb[i] = 1'b0; cyc[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack0", 32'(ack[0]), 32'd0);
    chk("reset_dat0", rdat[0], 32'd0);
    chk("reset_ack1", 32'(ack[1]), 32'd0);
    chk("reset_err0", 32'(err[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, ackv, errv);
    chk("wr10_lat", 32'(lat), 32'd2);
    chk("wr10_ack", 32'(ackv), 32'd1);
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, ackv, errv);
    chk("rd10_lat", 32'(lat), 32'd2);
    chk("rd10_dat", rd, 32'hDEADBEEF);
    chk("rd10_hold", rdat[0], 32'hDEADBEEF);

    req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, ackv, errv);
    chk("wr20_dat_unchanged", rdat[0], 32'hDEADBEEF);
    req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, lat, rd, ackv, errv);
    req(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("rd20_lanes", rd, 32'h11BB33DD);
    req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, rd, ackv, errv);
    chk("sel0_ack", 32'(ackv), 32'd1);
    chk("sel0_lat", 32'(lat), 32'd2);
    req(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, ackv, errv);
    chk("sel0_word", rd, 32'h11BB33DD);

    adr[0] = 32'h10; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("held_ack_%0d", k + 1), 32'(ack[0]), 32'(exp_held[k]));
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);

    req(1, 1'b1, 32'h40, 32'h01234567, 4'hF, lat, rd, ackv, errv);
    chk("wr40_lat_w3", 32'(lat), 32'd4);
    adr[1] = 32'h40; wdat[1] = 32'hCAFEF00D; we[1] = 1'b1; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort_noack_%0d", k), 32'(ack[1]), 32'd0);
    end
    req(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("rd40_lat", 32'(lat), 32'd4);
    chk("rd40_prior", rd, 32'h01234567);

    adr[0] = 32'h10; wdat[0] = 32'h55555555; we[0] = 1'b1; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack", 32'(ack[0]), 32'd0);
    chk("rstmid_dat", rdat[0], 32'd0);
    @(negedge clk);
    chk("rstmid_ack_after_edge", 32'(ack[0]), 32'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    req(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("rstmid_rd_lat", 32'(lat), 32'd2);
    chk("rstmid_rd10", rd, 32'hDEADBEEF);

    req(0, 1'b1, 32'h1010, 32'h0BADF00D, 4'hF, lat, rd, ackv, errv);
    chk("wrap_lat", 32'(lat), 32'd2);
`ifdef WB_MEM_SLAVE_ERR_EN
    chk("oob_err", 32'(errv), 32'd1);
    chk("oob_ack", 32'(ackv), 32'd0);
    chk("oob_dat_unchanged", rd, 32'hDEADBEEF);
    req(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("oob_rd10", rd, 32'hDEADBEEF);
    req(0, 1'b0, 32'h12, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("misalign_err", 32'(errv), 32'd1);
    chk("misalign_ack", 32'(ackv), 32'd0);
`else
    chk("wrap_ack", 32'(ackv), 32'd1);
    req(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("wrap_rd10", rd, 32'h0BADF00D);
    req(0, 1'b0, 32'h12, 32'h0, 4'hF, lat, rd, ackv, errv);
    chk("lowbits_ack", 32'(ackv), 32'd1);
    chk("lowbits_rd", rd, 32'h0BADF00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
